// File: rtl/jtag_tap_ctrl_pkg.sv
// jtag_pkg: TAP state encodings and the 1149.1 next-state function
package jtag_pkg;
  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SHIFT_DR = 4'h2,
    EXIT1_DR = 4'h1,
    PAUSE_DR = 4'h3,
    EXIT2_DR = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SHIFT_IR = 4'hA,
    EXIT1_IR = 4'h9,
    PAUSE_IR = 4'hB,
    EXIT2_IR = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  function automatic tap_state_e tap_next(tap_state_e s, logic tms);
    tap_state_e n;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: JTAG pins plus IR/DR chain control bundle
interface jtag_tap_ctrl_if;
  logic       tck;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic       s_data_out;
  logic       ir_s_data_in;
  logic       dr_s_data_in;
  logic       shift_ir;
  logic       clk_ir;
  logic       update_ir;
  logic       shift_dr;
  logic       clk_dr;
  logic       update_dr;
  logic       tlr;
  logic [3:0] tap_state;
  modport master (
    output tck, tms, tdi, ir_s_data_in, dr_s_data_in,
    input  tdo, tdo_en, s_data_out, shift_ir, clk_ir, update_ir,
           shift_dr, clk_dr, update_dr, tlr, tap_state
  );
  modport slave (
    input  tck, tms, tdi, ir_s_data_in, dr_s_data_in,
    output tdo, tdo_en, s_data_out, shift_ir, clk_ir, update_ir,
           shift_dr, clk_dr, update_dr, tlr, tap_state
  );
endinterface

// File: rtl/jtag_pin_sync.sv
// jtag_pin_sync: pin synchronizers and tck edge detect; JTAG_TCK_FILTER_EN adds a 2-cycle glitch filter
module jtag_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic ICLK,
  input  logic reset,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);
  logic [SYNC_STAGES-1:0] tck_q, tms_q, tdi_q;
  logic tck_s, hist;
  assign tck_s = tck_q[SYNC_STAGES-1];
  assign tms_s = tms_q[SYNC_STAGES-1];
  assign tdi_s = tdi_q[SYNC_STAGES-1];
  // synchronizer shift chains plus the history flop on synchronized tck
  always_ff @(posedge ICLK or negedge reset)
    if (!reset) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
      hist  <= 1'b0;
    end else begin
      tck_q <= {tck_q[SYNC_STAGES-2:0], tck};
      tms_q <= {tms_q[SYNC_STAGES-2:0], tms};
      tdi_q <= {tdi_q[SYNC_STAGES-2:0], tdi};
      hist  <= tck_s;
    end
`ifdef JTAG_TCK_FILTER_EN
  logic lvl;
  // accepted tck level only follows once the synchronized level held for two cycles
  always_ff @(posedge ICLK or negedge reset)
    if (!reset) lvl <= 1'b0;
    else lvl <= (tck_s == hist) ? tck_s : lvl;
  assign tck_rise = tck_s & hist & ~lvl;
  assign tck_fall = ~tck_s & ~hist & lvl;
`else
  assign tck_rise = tck_s & ~hist;
  assign tck_fall = ~tck_s & hist;
`endif
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: 1149.1 TAP controller in the ICLK domain (optional tck glitch filter: JTAG_TCK_FILTER_EN)
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            ICLK,
  input  logic            reset,
  jtag_tap_ctrl_if.slave  jtag
);
  tap_state_e state, state_nxt;
  logic tck_rise, tck_fall, tms_s, tdi_s;
  logic clk_ir_q, clk_dr_q, upd_ir_q, upd_dr_q, sh_ir_q, sh_dr_q, tdo_q, tdo_en_q;
  logic clk_ir_nxt, clk_dr_nxt, upd_ir_nxt, upd_dr_nxt, sh_ir_nxt, sh_dr_nxt, tdo_nxt, tdo_en_nxt;

  jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .ICLK     (ICLK),
    .reset    (reset),
    .tck      (jtag.tck),
    .tms      (jtag.tms),
    .tdi      (jtag.tdi),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  // next state and strobes; strobes see the pre-transition state, shift levels lag the state by one cycle
  always_comb begin
    state_nxt  = tck_rise ? tap_next(state, tms_s) : state;
    clk_ir_nxt = tck_rise & (state == CAP_IR || state == SHIFT_IR);
    clk_dr_nxt = tck_rise & (state == CAP_DR || state == SHIFT_DR);
    upd_ir_nxt = tck_fall & (state == UPD_IR);
    upd_dr_nxt = tck_fall & (state == UPD_DR);
    sh_ir_nxt  = state == SHIFT_IR;
    sh_dr_nxt  = state == SHIFT_DR;
    tdo_nxt    = !tck_fall ? tdo_q :
                 state == SHIFT_IR ? jtag.ir_s_data_in :
                 state == SHIFT_DR ? jtag.dr_s_data_in : 1'b0;
    tdo_en_nxt = tck_fall ? (state == SHIFT_IR || state == SHIFT_DR) : tdo_en_q;
  end

  // state and registered outputs
  always_ff @(posedge ICLK or negedge reset)
    if (!reset) begin
      state    <= TLR;
      clk_ir_q <= 1'b0;
      clk_dr_q <= 1'b0;
      upd_ir_q <= 1'b0;
      upd_dr_q <= 1'b0;
      sh_ir_q  <= 1'b0;
      sh_dr_q  <= 1'b0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      clk_ir_q <= clk_ir_nxt;
      clk_dr_q <= clk_dr_nxt;
      upd_ir_q <= upd_ir_nxt;
      upd_dr_q <= upd_dr_nxt;
      sh_ir_q  <= sh_ir_nxt;
      sh_dr_q  <= sh_dr_nxt;
      tdo_q    <= tdo_nxt;
      tdo_en_q <= tdo_en_nxt;
    end

  assign jtag.clk_ir     = clk_ir_q;
  assign jtag.clk_dr     = clk_dr_q;
  assign jtag.update_ir  = upd_ir_q;
  assign jtag.update_dr  = upd_dr_q;
  assign jtag.shift_ir   = sh_ir_q;
  assign jtag.shift_dr   = sh_dr_q;
  assign jtag.tdo        = tdo_q;
  assign jtag.tdo_en     = tdo_en_q;
  assign jtag.s_data_out = tdi_s;
  assign jtag.tlr        = state == TLR;
  assign jtag.tap_state  = state;
endmodule
